// File: rtl/sport0_tx_pkg.sv
// Shared encodings for the SPORT0 transmit control: FSM states and DTYPE field values.
package sport0_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } tx_state_e;

  localparam logic [1:0] DT_ZERO = 2'b00;
  localparam logic [1:0] DT_SIGN = 2'b01;
  localparam logic [1:0] DT_ULAW = 2'b10;
  localparam logic [1:0] DT_ALAW = 2'b11;

  // Both compander encodings route TX through the cmpTX writeback.
  function automatic logic is_companded(input logic [1:0] dtype);
    return (dtype == DT_ULAW) || (dtype == DT_ALAW);
  endfunction

endpackage

// File: rtl/sport0_tx_shifter.sv
// Transmit shift register with bit and word counters; loads left-justified words.
module sport0_tx_shifter #(
  parameter int WL = 16,
  parameter int BW = $clog2(WL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          start,
  input  logic          reload,
  input  logic          shift,
  input  logic [WL-1:0] tx,
  input  logic [BW-1:0] slen,
  input  logic [7:0]    mword,
  output logic          msb,
  output logic          bcnt_zero,
  output logic          wcnt_zero
);

  logic [WL-1:0] txsht;
  logic [BW-1:0] bcnt;
  logic [7:0]    wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txsht <= '0;
      bcnt  <= '0;
      wcnt  <= '0;
    end else if (clr) begin
      bcnt <= '0;
      wcnt <= '0;
    end else if (start || reload) begin
      // Left-justify so the word's MSB sits at the serial output.
      txsht <= tx << (BW'(WL-1) - slen);
      bcnt  <= slen;
      wcnt  <= start ? mword : wcnt - 8'd1;
    end else if (shift) begin
      txsht <= {txsht[WL-2:0], 1'b0};
      bcnt  <= bcnt - 1'b1;
    end
  end

  assign msb       = txsht[WL-1];
  assign bcnt_zero = (bcnt == '0);
  assign wcnt_zero = (wcnt == '0);

endmodule

// File: rtl/sport0_tx_ctl.sv
// SPORT0 transmit control: TX buffer, frame FSM, autobuffer request and interrupt.
module sport0_tx_ctl
  import sport0_tx_pkg::*;
#(
  parameter int WL = 16
) (
  input  logic          DSPCLK,
  input  logic          RST_,
  input  logic          SP_EN,
  input  logic          SCLK_en,
  input  logic          TFSsm,
  input  logic [4:0]    SLEN,
  input  logic [7:0]    MWORD,
  input  logic [1:0]    DTYPE,
  input  logic          TBUF,
  input  logic          Twrap,
  input  logic          TSack,
  input  logic          MTTX_E,
  input  logic [WL-1:0] DMD,
  input  logic [WL-1:0] cmpTX,
  output logic [WL-1:0] TX,
  output logic          DT,
  output logic          DT_OE,
  output logic          TSreq,
  output logic          ISX,
  output logic          TUNDR
);

  localparam int BW = $clog2(WL);

  tx_state_e     state;
  logic          txfull, ld_cmp, xfer_d, tsack_r, isx_r;
  logic          start, reload, shift, xfer, ts_set, comp;
  logic          msb, bcnt_zero, wcnt_zero;
  logic [BW-1:0] slen_eff;

  assign slen_eff = (SLEN > 5'(WL-1)) ? BW'(WL-1) : SLEN[BW-1:0];
  assign comp     = is_companded(DTYPE);

  assign start  = SP_EN && SCLK_en && (state == IDLE) && TFSsm;
  assign reload = SP_EN && SCLK_en && (state == SHIFT) && bcnt_zero && !wcnt_zero;
  assign shift  = SP_EN && SCLK_en && (state == SHIFT) && !bcnt_zero;
  assign xfer   = start || reload;

  // With companding, the request waits one extra cycle for the cmpTX writeback.
  assign ts_set = SP_EN && TBUF && (comp ? xfer_d : xfer);

  sport0_tx_shifter #(.WL(WL), .BW(BW)) u_shifter (
    .clk       (DSPCLK),
    .rst_n     (RST_),
    .clr       (!SP_EN),
    .start     (start),
    .reload    (reload),
    .shift     (shift),
    .tx        (TX),
    .slen      (slen_eff),
    .mword     (MWORD),
    .msb       (msb),
    .bcnt_zero (bcnt_zero),
    .wcnt_zero (wcnt_zero)
  );

  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) begin
      state <= IDLE;
      DT_OE <= 1'b0;
    end else if (!SP_EN) begin
      state <= IDLE;
      DT_OE <= 1'b0;
    end else if (SCLK_en) begin
      case (state)
        IDLE: if (TFSsm) begin
          state <= SHIFT;
          DT_OE <= 1'b1;
        end
        SHIFT: if (bcnt_zero && wcnt_zero) begin
          state <= IDLE;
          DT_OE <= 1'b0;
        end
        default: begin
          state <= IDLE;
          DT_OE <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) begin
      TX      <= '0;
      txfull  <= 1'b0;
      ld_cmp  <= 1'b0;
      TUNDR   <= 1'b0;
      xfer_d  <= 1'b0;
      tsack_r <= 1'b0;
      isx_r   <= 1'b0;
      TSreq   <= 1'b0;
    end else begin
      // A fresh core write always wins and re-arms the compander writeback.
      ld_cmp <= MTTX_E && comp;
      if (MTTX_E)      TX <= DMD;
      else if (ld_cmp) TX <= cmpTX;

      if (MTTX_E)    txfull <= 1'b1;
      else if (xfer) txfull <= 1'b0;

      if (!SP_EN)              TUNDR <= 1'b0;
      else if (xfer && !txfull) TUNDR <= 1'b1;

      xfer_d  <= xfer;
      tsack_r <= TSack;
      isx_r   <= SP_EN && xfer;

      if (ts_set)       TSreq <= 1'b1;
      else if (tsack_r) TSreq <= 1'b0;
    end
  end

  assign DT  = DT_OE && msb;
  assign ISX = TBUF ? Twrap : isx_r;

endmodule

// File: tb/tb_sport0_tx_ctl.sv
// Directed bench for sport0_tx_ctl: single/short/multichannel frames, underflow, autobuffer, reset/disable.
module tb_sport0_tx_ctl;

  logic        DSPCLK = 1'b0;
  logic        RST_ = 1'b0;
  logic        SP_EN = 1'b0, SCLK_en = 1'b0, TFSsm = 1'b0;
  logic [4:0]  SLEN = 5'd15;
  logic [7:0]  MWORD = 8'd0;
  logic [1:0]  DTYPE = 2'b00;
  logic        TBUF = 1'b0, Twrap = 1'b0, TSack = 1'b0, MTTX_E = 1'b0;
  logic [15:0] DMD = 16'h0, cmpTX = 16'h0;
  logic [15:0] TX;
  logic        DT, DT_OE, TSreq, ISX, TUNDR;

  int errors = 0;
  int checks = 0;
  int isx_cnt = 0;
  int oe_ticks = 0;
  logic [31:0] word;

  sport0_tx_ctl dut (
    .DSPCLK(DSPCLK), .RST_(RST_), .SP_EN(SP_EN), .SCLK_en(SCLK_en), .TFSsm(TFSsm),
    .SLEN(SLEN), .MWORD(MWORD), .DTYPE(DTYPE), .TBUF(TBUF), .Twrap(Twrap),
    .TSack(TSack), .MTTX_E(MTTX_E), .DMD(DMD), .cmpTX(cmpTX), .TX(TX), .DT(DT),
    .DT_OE(DT_OE), .TSreq(TSreq), .ISX(ISX), .TUNDR(TUNDR)
  );

  always #5 DSPCLK = ~DSPCLK;

  always @(negedge DSPCLK) begin
    if (ISX) isx_cnt++;
    if (SCLK_en && DT_OE) oe_ticks++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge DSPCLK);
    #1;
  endtask

  task automatic tick();
    SCLK_en = 1'b1; cyc();
    SCLK_en = 1'b0; cyc();
  endtask

  task automatic wr(input logic [15:0] d);
    MTTX_E = 1'b1; DMD = d; cyc();
    MTTX_E = 1'b0;
  endtask

  task automatic start_frame();
    TFSsm = 1'b1; SCLK_en = 1'b1; cyc();
    TFSsm = 1'b0; SCLK_en = 1'b0; cyc();
  endtask

  task automatic collect(input int n, output logic [31:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = {w[30:0], DT};
      tick();
    end
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_TX", 32'(TX), 32'h0);
    chk("rst_DT", 32'(DT), 32'h0);
    chk("rst_DT_OE", 32'(DT_OE), 32'h0);
    chk("rst_TSreq", 32'(TSreq), 32'h0);
    chk("rst_ISX", 32'(ISX), 32'h0);
    chk("rst_TUNDR", 32'(TUNDR), 32'h0);
    RST_ = 1'b1; SP_EN = 1'b1; cyc();

    // single 16-bit word
    wr(16'hA5C3);
    chk("single_TX", 32'(TX), 32'hA5C3);
    isx_cnt = 0; oe_ticks = 0;
    start_frame();
    chk("single_DT_OE_on", 32'(DT_OE), 32'h1);
    collect(16, word);
    chk("single_bits", word, 32'h0000A5C3);
    chk("single_oe_ticks", 32'(oe_ticks), 32'd16);
    chk("single_idle", 32'(DT_OE), 32'h0);
    chk("single_isx", 32'(isx_cnt), 32'd1);
    chk("single_tundr", 32'(TUNDR), 32'h0);

    // short 8-bit word
    SLEN = 5'd7;
    wr(16'h00B2);
    oe_ticks = 0;
    start_frame();
    collect(8, word);
    chk("short_bits", word, 32'h000000B2);
    chk("short_oe_ticks", 32'(oe_ticks), 32'd8);
    chk("short_idle", 32'(DT_OE), 32'h0);

    // multichannel, three words back to back
    MWORD = 8'd2;
    wr(16'h0011);
    isx_cnt = 0; oe_ticks = 0;
    start_frame();
    wr(16'h0022);
    word = '0;
    for (int i = 0; i < 24; i++) begin
      word = {word[30:0], DT};
      tick();
      if (i == 7) wr(16'h0033);
    end
    chk("multi_bits", word, 32'h00112233);
    chk("multi_oe_ticks", 32'(oe_ticks), 32'd24);
    chk("multi_xfers", 32'(isx_cnt), 32'd3);
    chk("multi_tundr", 32'(TUNDR), 32'h0);

    // underflow: second word not rewritten
    MWORD = 8'd1;
    wr(16'h005A);
    start_frame();
    collect(16, word);
    chk("undr_bits", word, 32'h00005A5A);
    chk("undr_tundr", 32'(TUNDR), 32'h1);
    SP_EN = 1'b0; cyc();
    chk("undr_clr", 32'(TUNDR), 32'h0);
    SP_EN = 1'b1; cyc();

    // collision: core write on the xfer cycle
    MWORD = 8'd0;
    wr(16'h003C);
    TFSsm = 1'b1; SCLK_en = 1'b1; MTTX_E = 1'b1; DMD = 16'h00C3; cyc();
    TFSsm = 1'b0; SCLK_en = 1'b0; MTTX_E = 1'b0; cyc();
    chk("coll_TX", 32'(TX), 32'h00C3);
    collect(8, word);
    chk("coll_bits", word, 32'h0000003C);
    start_frame();
    collect(8, word);
    chk("coll_next_bits", word, 32'h000000C3);
    chk("coll_full_kept", 32'(TUNDR), 32'h0);

    // autobuffer with companding
    TBUF = 1'b1; DTYPE = 2'b10; cmpTX = 16'h0077;
    wr(16'h0012);
    chk("ab_TX_core", 32'(TX), 32'h0012);
    cyc();
    chk("ab_TX_cmp", 32'(TX), 32'h0077);
    TFSsm = 1'b1; SCLK_en = 1'b1; cyc();
    TFSsm = 1'b0; SCLK_en = 1'b0;
    chk("ab_tsreq_xfer1", 32'(TSreq), 32'h0);
    cyc();
    chk("ab_tsreq_xfer2", 32'(TSreq), 32'h1);
    TSack = 1'b1; cyc();
    TSack = 1'b0;
    chk("ab_tsreq_hold", 32'(TSreq), 32'h1);
    cyc();
    chk("ab_tsreq_clr", 32'(TSreq), 32'h0);
    Twrap = 1'b1; #1;
    chk("ab_isx_wrap1", 32'(ISX), 32'h1);
    Twrap = 1'b0; #1;
    chk("ab_isx_wrap0", 32'(ISX), 32'h0);
    collect(8, word);
    chk("ab_bits", word, 32'h00000077);
    TBUF = 1'b0; DTYPE = 2'b00;

    // async reset mid-frame
    SLEN = 5'd15;
    wr(16'hFFFF);
    start_frame();
    for (int i = 0; i < 5; i++) tick();
    chk("rstm_DT_OE", 32'(DT_OE), 32'h1);
    chk("rstm_DT", 32'(DT), 32'h1);
    #2; RST_ = 1'b0; #1;
    chk("rstm_DT_OE0", 32'(DT_OE), 32'h0);
    chk("rstm_DT0", 32'(DT), 32'h0);
    chk("rstm_TX0", 32'(TX), 32'h0);
    #2; RST_ = 1'b1; cyc();

    // disable mid-frame
    wr(16'hABCD);
    start_frame();
    for (int i = 0; i < 3; i++) tick();
    chk("dis_DT_OE_on", 32'(DT_OE), 32'h1);
    SP_EN = 1'b0; cyc();
    chk("dis_DT_OE", 32'(DT_OE), 32'h0);
    chk("dis_TX", 32'(TX), 32'hABCD);
    tick();
    chk("dis_stays_idle", 32'(DT_OE), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
